// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner pipeline back end.
package harris_pkg;

    localparam int SCORE_W = 64;
    localparam int COORD_W = 16;

    localparam logic signed [SCORE_W-1:0] DEF_THRESH = 64'sd65536;

    // One detected corner: position of the window center plus its score.
    typedef struct packed {
        logic [COORD_W-1:0]        x;
        logic [COORD_W-1:0]        y;
        logic signed [SCORE_W-1:0] score;
    } corner_t;

endpackage

// File: rtl/harris_corner_fifo.sv
// Synchronous FIFO of corner records with full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module harris_corner_fifo
    import harris_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  corner_t data_i,
    input  logic    pop_i,
    output corner_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);

    corner_t         mem_q [DEPTH];
    logic [AW:0]     wr_q;
    logic [AW:0]     rd_q;
    logic            wr_en;
    logic            rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);

    // Head entry is forced to zero while empty so outputs are defined out of reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    // Read and write pointers with wrap bit for full/empty distinction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/harris_corner_nms.sv
// Harris score threshold plus 3x3 non-maximum suppression over a raster
// stream; surviving corners are queued as (x, y, score) records.
module harris_corner_nms
    import harris_pkg::*;
#(
    parameter int                        IMG_W      = 64,
    parameter int                        IMG_H      = 64,
    parameter logic signed [SCORE_W-1:0] THRESH     = DEF_THRESH,
    parameter int                        FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      r_valid,
    input  logic signed [SCORE_W-1:0] r_score,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COORD_W-1:0]        out_x,
    output logic [COORD_W-1:0]        out_y,
    output logic signed [SCORE_W-1:0] out_score,
    output logic                      overflow,
    output logic                      frame_done
);

    localparam int                 XW     = $clog2(IMG_W);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
    logic [XW-1:0]             xi;
    logic                      x_last, y_last;
    logic                      eval_q, push_q, overflow_q, frame_done_q;
    logic [COORD_W-1:0]        cx_q, cy_q;
    logic signed [SCORE_W-1:0] lb1_q [IMG_W];
    logic signed [SCORE_W-1:0] lb2_q [IMG_W];
    logic signed [SCORE_W-1:0] w_q [3][3];
    logic signed [SCORE_W-1:0] center;
    logic                      is_corner;
    corner_t                   rec_q, head;
    logic                      fifo_full, fifo_empty, pop;

    assign xi     = x_q[XW-1:0];
    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);
    assign center = w_q[1][1];

    // Next raster position.
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + 1'b1;
        end
    end

    // Position counters, evaluation strobe, push strobe, sticky overflow and frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            eval_q       <= 1'b0;
            push_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= r_valid && x_last && y_last;
            eval_q       <= r_valid && (x_q >= 16'd2) && (y_q >= 16'd2);
            push_q       <= eval_q && is_corner;
            if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
            if (r_valid) begin
                x_q <= x_d;
                y_q <= y_d;
            end
        end
    end

    // Line buffers and 3x3 window; column 2 is the newest, row 2 the current row.
    always_ff @(posedge clk) begin
        if (r_valid) begin
            lb2_q[xi] <= lb1_q[xi];
            lb1_q[xi] <= r_score;
            for (int unsigned r = 0; r < 3; r++) begin
                w_q[r][0] <= w_q[r][1];
                w_q[r][1] <= w_q[r][2];
            end
            w_q[0][2] <= lb2_q[xi];
            w_q[1][2] <= lb1_q[xi];
            w_q[2][2] <= r_score;
            cx_q      <= x_q - 1'b1;
            cy_q      <= y_q - 1'b1;
        end
    end

    // Threshold and NMS: strict against raster-earlier neighbours, non-strict
    // against raster-later ones so a plateau yields only its first pixel.
    always_comb begin
        is_corner = (center > THRESH);
        for (int unsigned c = 0; c < 3; c++) begin
            is_corner = is_corner && (center > w_q[0][c]) && (center >= w_q[2][c]);
        end
        is_corner = is_corner && (center > w_q[1][0]) && (center >= w_q[1][2]);
    end

    // Registered corner record presented to the FIFO.
    always_ff @(posedge clk) begin
        rec_q <= '{x: cx_q, y: cy_q, score: center};
    end

    assign pop = out_ready && !fifo_empty;

    harris_corner_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_q),
        .data_i  (rec_q),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_x      = head.x;
    assign out_y      = head.y;
    assign out_score  = head.score;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_harris_corner_nms.sv
// Directed bench for harris_corner_nms: 8x8 instance with a scoreboard,
// 16x16 instance for FIFO backpressure and overflow.
module tb_harris_corner_nms;

    localparam logic signed [63:0] TH = 64'sd65536;

    typedef struct {
        logic [15:0]        x;
        logic [15:0]        y;
        logic signed [63:0] s;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    // 8x8 instance
    logic               a_valid, a_ready, a_out_valid, a_overflow, a_frame_done;
    logic signed [63:0] a_score, a_out_score;
    logic [15:0]        a_out_x, a_out_y;

    harris_corner_nms #(.IMG_W(8), .IMG_H(8), .THRESH(TH), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .reset(rst), .r_valid(a_valid), .r_score(a_score),
        .out_valid(a_out_valid), .out_ready(a_ready), .out_x(a_out_x), .out_y(a_out_y),
        .out_score(a_out_score), .overflow(a_overflow), .frame_done(a_frame_done));

    // 16x16 instance
    logic               b_valid, b_ready, b_out_valid, b_overflow, b_frame_done;
    logic signed [63:0] b_score, b_out_score;
    logic [15:0]        b_out_x, b_out_y;

    harris_corner_nms #(.IMG_W(16), .IMG_H(16), .THRESH(TH), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(rst), .r_valid(b_valid), .r_score(b_score),
        .out_valid(b_out_valid), .out_ready(b_ready), .out_x(b_out_x), .out_y(b_out_y),
        .out_score(b_out_score), .overflow(b_overflow), .frame_done(b_frame_done));

    logic signed [63:0] img  [64];
    logic signed [63:0] bimg [256];
    rec_t               exp_q [$];

    int   a_recv     = 0;
    int   a_fd_cnt   = 0;
    int   a_rise_cyc = 0;
    logic a_prev_v   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input logic signed [63:0] v);
        for (int i = 0; i < 64; i++) img[i] = v;
    endtask

    // Reference rule: strict vs raster-earlier neighbours, >= vs raster-later.
    task automatic model_push();
        for (int cy = 1; cy < 7; cy++) begin
            for (int cx = 1; cx < 7; cx++) begin
                logic signed [63:0] c;
                logic ok;
                c  = img[cy*8 + cx];
                ok = (c > TH);
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        logic signed [63:0] n;
                        n = img[(cy+dy)*8 + cx + dx];
                        if (dy < 0 || (dy == 0 && dx < 0)) ok = ok && (c > n);
                        else if (dy > 0 || dx > 0)        ok = ok && (c >= n);
                    end
                end
                if (ok) exp_q.push_back('{x: 16'(cx), y: 16'(cy), s: c});
            end
        end
    endtask

    task automatic send_frame(input int lat_idx);
        int acc_cyc;
        acc_cyc = 0;
        model_push();
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            a_valid = 1'b1;
            a_score = img[i];
            if (i == lat_idx) acc_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("frame_done_pulse", 64'(a_frame_done), 64'd1);
        @(negedge clk);
        chk("frame_done_low", 64'(a_frame_done), 64'd0);
        repeat (6) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        if (lat_idx >= 0) chk("latency", 64'(a_rise_cyc - acc_cyc), 64'd2);
    endtask

    // Scoreboard monitor for the 8x8 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_frame_done) a_fd_cnt++;
            if (a_out_valid && !a_prev_v) a_rise_cyc = cyc;
            a_prev_v = a_out_valid;
            if (a_out_valid && a_ready) begin
                a_recv++;
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_record observed=(%0d,%0d,%0d) expected=none",
                           a_out_x, a_out_y, a_out_score);
                end
                if (exp_q.size() != 0) begin
                    rec_t e;
                    e = exp_q.pop_front();
                    n_vec++;
                    assert (a_out_x === e.x && a_out_y === e.y && a_out_score === e.s) else begin
                        n_err++;
                        $error("FAIL record observed=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)",
                               a_out_x, a_out_y, a_out_score, e.x, e.y, e.s);
                    end
                end
            end
        end
    end

    initial begin
        int r0, fd0;
        rst = 1'b1;
        a_valid = 1'b0; a_score = '0; a_ready = 1'b1;
        b_valid = 1'b0; b_score = '0; b_ready = 1'b0;
        repeat (3) @(posedge clk); #1;

        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_x", 64'(a_out_x), 64'd0);
        chk("rst_out_y", 64'(a_out_y), 64'd0);
        chk("rst_out_score", a_out_score, 64'd0);
        chk("rst_overflow", 64'(a_overflow), 64'd0);
        chk("rst_frame_done", 64'(a_frame_done), 64'd0);
        rst = 1'b0;

        // All-zero frame
        r0 = a_recv; fd0 = a_fd_cnt;
        fill(0);
        send_frame(-1);
        chk("zero_records", 64'(a_recv - r0), 64'd0);
        chk("zero_fd_count", 64'(a_fd_cnt - fd0), 64'd1);
        chk("zero_rise_never", 64'(a_rise_cyc), 64'd0);

        // Single peak at (3,4); center evaluated when (4,5) = index 44 arrives
        r0 = a_recv;
        fill(0); img[4*8+3] = 64'sd100000;
        send_frame(44);
        chk("peak_records", 64'(a_recv - r0), 64'd1);

        // Threshold edge: 65536 rejected, 65537 accepted
        r0 = a_recv;
        fill(0); img[2*8+2] = 64'sd65536; img[5*8+5] = 64'sd65537;
        send_frame(-1);
        chk("thresh_records", 64'(a_recv - r0), 64'd1);

        // Negative peak on negative background
        r0 = a_recv;
        fill(-64'sd100); img[3*8+3] = -64'sd5;
        send_frame(-1);
        chk("negative_records", 64'(a_recv - r0), 64'd0);

        // Plateau: only the first pixel in raster order
        r0 = a_recv;
        fill(0); img[3*8+3] = 64'sd200000; img[3*8+4] = 64'sd200000;
        send_frame(-1);
        chk("plateau_records", 64'(a_recv - r0), 64'd1);

        // Border peaks are never centers
        r0 = a_recv;
        fill(0); img[3*8+0] = 64'sd300000; img[7*8+7] = 64'sd300000;
        send_frame(-1);
        chk("border_records", 64'(a_recv - r0), 64'd0);

        // Backpressure on 16x16: 20 isolated peaks, FIFO holds 16
        for (int i = 0; i < 256; i++) bimg[i] = '0;
        for (int k = 0; k < 20; k++) bimg[(1 + 2*(k/7))*16 + 1 + 2*(k%7)] = 64'sd100000;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            b_valid = 1'b1;
            b_score = bimg[i];
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_overflow", 64'(b_overflow), 64'd1);
        chk("bp_valid_held", 64'(b_out_valid), 64'd1);
        @(posedge clk); #1;
        b_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("bp_drain_valid", 64'(b_out_valid), 64'd1);
            chk("bp_drain_x", 64'(b_out_x), 64'(1 + 2*(k%7)));
            chk("bp_drain_y", 64'(b_out_y), 64'(1 + 2*(k/7)));
            chk("bp_drain_score", b_out_score, 64'd100000);
        end
        @(negedge clk);
        chk("bp_empty_after", 64'(b_out_valid), 64'd0);
        chk("bp_overflow_sticky", 64'(b_overflow), 64'd1);

        // Reset mid-frame with three records queued
        a_ready = 1'b0;
        fill(0); img[9] = 64'sd100000; img[11] = 64'sd100000; img[13] = 64'sd100000;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            a_valid = 1'b1;
            a_score = img[i];
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("mid_queued_valid", 64'(a_out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_overflow", 64'(a_overflow), 64'd0);
        chk("mid_rst_bp_overflow", 64'(b_overflow), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_ready = 1'b1;
        r0 = a_recv;
        fill(0); img[4*8+3] = 64'sd100000;
        send_frame(44);
        chk("post_reset_records", 64'(a_recv - r0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
